// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg -- shared constants and helpers for the branch history table.
//
// Holds the PC slicing layout (word-aligned index just above the byte
// offset, tag directly above the index), the fixed PC/target widths and
// the counter initial values. Width-dependent values are provided as
// constant functions so every module derives them the same way from its
// own ENTRIES / CTR_BITS parameters.
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam int unsigned PC_W     = 32;  // PC width
   localparam int unsigned TARGET_W = 32;  // stored target width
   localparam int unsigned IDX_LSB  = 2;   // instructions are word aligned

   // Number of index bits for a table of 'entries' rows.
   function automatic int unsigned idx_bits(input int unsigned entries);
      return $clog2(entries);
   endfunction

   // Lowest PC bit of the tag field (first bit above the index).
   function automatic int unsigned tag_lsb(input int unsigned entries);
      return IDX_LSB + $clog2(entries);
   endfunction

   // Counter value loaded on allocation: lowest "taken" value.
   function automatic int unsigned ctr_weak_taken(input int unsigned ctr_bits);
      return 32'd1 << (ctr_bits - 1);
   endfunction

   // Counter value after reset: highest "not-taken" value.
   function automatic int unsigned ctr_weak_not_taken(input int unsigned ctr_bits);
      return (32'd1 << (ctr_bits - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// ---------------------------------------------------------------------------
// bp_sat_ctr -- combinational saturating up/down counter step.
//
// Ports:
//   ctr_i  : current counter value
//   inc_i  : 1 = count up (branch taken), 0 = count down (not taken)
//   ctr_o  : next counter value, clamped to 0 .. 2^CTR_BITS-1
// ---------------------------------------------------------------------------
module bp_sat_ctr #(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr_i,
   input  logic                inc_i,
   output logic [CTR_BITS-1:0] ctr_o
);

   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_BITS'(1);
      end else begin
         if (ctr_i != CTR_MIN) ctr_o = ctr_i - CTR_BITS'(1);
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht -- direct-mapped branch history / target table.
//
// Lookup side (ID stage, combinational):
//   lookup_valid, pc_in, pc_plus_4_in, is_branch, is_jump
//   -> btb_hit, branch_prediction, predicted_target
// Update side (EX/MEM, registered on rising clk):
//   update_valid, update_pc, update_taken, update_target,
//   update_is_jump, update_mispredict
// Control: flush_table invalidates every entry in one cycle.
// Perf:    perf_lookups, perf_mispredicts (free-running, wrap at 2^32).
// Reset:   rst is asynchronous, active low.
// ---------------------------------------------------------------------------
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES  = 64,
   parameter int unsigned CTR_BITS = 2,
   parameter int unsigned TAG_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lookup_valid,
   input  logic [PC_W-1:0]     pc_in,
   input  logic [PC_W-1:0]     pc_plus_4_in,
   input  logic                is_branch,
   input  logic                is_jump,
   output logic                branch_prediction,
   output logic [PC_W-1:0]     predicted_target,
   output logic                btb_hit,
   input  logic                update_valid,
   input  logic [PC_W-1:0]     update_pc,
   input  logic                update_taken,
   input  logic [TARGET_W-1:0] update_target,
   input  logic                update_is_jump,
   input  logic                update_mispredict,
   input  logic                flush_table,
   output logic [31:0]         perf_lookups,
   output logic [31:0]         perf_mispredicts
);

   localparam int unsigned IDX     = idx_bits(ENTRIES);
   localparam int unsigned TAG_LSB = tag_lsb(ENTRIES);
   localparam int unsigned TAG_MSB = TAG_LSB + TAG_BITS - 1;

   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

   // Table state
   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic                jump_q   [ENTRIES];
   logic [TARGET_W-1:0] target_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

   logic [31:0] perf_lookups_q, perf_lookups_d;
   logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

   // ---------------- lookup (combinational, reads pre-update state) -------
   logic [IDX-1:0]      lk_idx;
   logic [TAG_BITS-1:0] lk_tag;
   logic                lk_req;

   assign lk_idx = pc_in[TAG_LSB-1:IDX_LSB];
   assign lk_tag = pc_in[TAG_MSB:TAG_LSB];
   assign lk_req = lookup_valid & (is_branch | is_jump);

   // rst gating keeps the outputs quiet for the whole reset window,
   // independent of when the asynchronous clear lands.
   assign btb_hit = rst & lk_req & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
   assign branch_prediction = btb_hit & (jump_q[lk_idx] | ctr_q[lk_idx][CTR_BITS-1]);
   assign predicted_target  = branch_prediction ? target_q[lk_idx] : pc_plus_4_in;

   // ---------------- update ------------------------------------------------
   logic [IDX-1:0]      up_idx;
   logic [TAG_BITS-1:0] up_tag;
   logic                up_hit;
   logic [CTR_BITS-1:0] up_ctr_d;

   assign up_idx = update_pc[TAG_LSB-1:IDX_LSB];
   assign up_tag = update_pc[TAG_MSB:TAG_LSB];
   assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

   bp_sat_ctr #(
      .CTR_BITS (CTR_BITS)
   ) u_sat_ctr (
      .ctr_i (ctr_q[up_idx]),
      .inc_i (update_taken),
      .ctr_o (up_ctr_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            jump_q[i]   <= 1'b0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else if (flush_table) begin
         // Flush takes priority; a concurrent update is dropped.
         for (int i = 0; i < int'(ENTRIES); i++) valid_q[i] <= 1'b0;
      end else if (update_valid) begin
         if (up_hit) begin
            ctr_q[up_idx] <= up_ctr_d;
            if (update_taken) begin
               target_q[up_idx] <= update_target;
               jump_q[up_idx]   <= update_is_jump;
            end
         end else if (update_taken) begin
            // Miss on a taken branch: replace whatever lives at this index.
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= update_target;
            jump_q[up_idx]   <= update_is_jump;
            ctr_q[up_idx]    <= CTR_WT;
         end
      end
   end

   // ---------------- performance counters ---------------------------------
   assign perf_lookups_d     = perf_lookups_q + {31'd0, lk_req};
   assign perf_mispredicts_d = perf_mispredicts_q + {31'd0, update_valid & update_mispredict};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_lookups_q     <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         perf_lookups_q     <= perf_lookups_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end

   assign perf_lookups     = perf_lookups_q;
   assign perf_mispredicts = perf_mispredicts_q;

   // Byte-offset and above-tag PC bits play no part in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_in[PC_W-1:TAG_MSB+1], pc_in[IDX_LSB-1:0],
                             update_pc[PC_W-1:TAG_MSB+1], update_pc[IDX_LSB-1:0]};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht -- directed vectors for the branch history table
// (ENTRIES=64, CTR_BITS=2, TAG_BITS=8: index = pc[7:2], tag = pc[15:8]).
// ---------------------------------------------------------------------------
module tb_branch_predictor_bht;

   logic        clk;
   logic        rst;
   logic        lookup_valid;
   logic [31:0] pc_in;
   logic [31:0] pc_plus_4_in;
   logic        is_branch;
   logic        is_jump;
   logic        branch_prediction;
   logic [31:0] predicted_target;
   logic        btb_hit;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_is_jump;
   logic        update_mispredict;
   logic        flush_table;
   logic [31:0] perf_lookups;
   logic [31:0] perf_mispredicts;

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_lookups;
   logic [31:0] exp_mispred;

   branch_predictor_bht #(
      .ENTRIES  (64),
      .CTR_BITS (2),
      .TAG_BITS (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .lookup_valid      (lookup_valid),
      .pc_in             (pc_in),
      .pc_plus_4_in      (pc_plus_4_in),
      .is_branch         (is_branch),
      .is_jump           (is_jump),
      .branch_prediction (branch_prediction),
      .predicted_target  (predicted_target),
      .btb_hit           (btb_hit),
      .update_valid      (update_valid),
      .update_pc         (update_pc),
      .update_taken      (update_taken),
      .update_target     (update_target),
      .update_is_jump    (update_is_jump),
      .update_mispredict (update_mispredict),
      .flush_table       (flush_table),
      .perf_lookups      (perf_lookups),
      .perf_mispredicts  (perf_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic idle();
      lookup_valid      = 1'b0;
      pc_in             = 32'h0;
      pc_plus_4_in      = 32'h4;
      is_branch         = 1'b0;
      is_jump           = 1'b0;
      update_valid      = 1'b0;
      update_pc         = 32'h0;
      update_taken      = 1'b0;
      update_target     = 32'h0;
      update_is_jump    = 1'b0;
      update_mispredict = 1'b0;
      flush_table       = 1'b0;
   endtask

   task automatic set_lookup(input logic [31:0] pc, input logic br, input logic jp);
      lookup_valid = 1'b1;
      pc_in        = pc;
      pc_plus_4_in = pc + 32'd4;
      is_branch    = br;
      is_jump      = jp;
   endtask

   task automatic set_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic jp, input logic misp);
      update_valid      = 1'b1;
      update_pc         = pc;
      update_taken      = taken;
      update_target     = tgt;
      update_is_jump    = jp;
      update_mispredict = misp;
   endtask

   // One clock; tracks the expected perf counts from the applied stimulus.
   task automatic tick(input string what);
      if (rst && lookup_valid && (is_branch || is_jump)) exp_lookups++;
      if (rst && update_valid && update_mispredict) exp_mispred++;
      $display("[%0t] %s lk=%0b pc=0x%08h up=%0b upc=0x%08h tk=%0b fl=%0b", $time, what,
               lookup_valid, pc_in, update_valid, update_pc, update_taken, flush_table);
      @(posedge clk);
      #1;
      idle();
   endtask

   // Apply a lone update and clock it in.
   task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic jp);
      set_update(pc, taken, tgt, jp, 1'b0);
      tick("update");
   endtask

   // Present a lookup, compare the combinational outputs, then clock it.
   task automatic do_lookup(input string tag, input logic [31:0] pc, input logic br, input logic jp,
                            input logic hit, input logic pred, input logic [31:0] tgt);
      set_lookup(pc, br, jp);
      #1;
      check({tag, ".hit"},  {31'd0, btb_hit},           {31'd0, hit});
      check({tag, ".pred"}, {31'd0, branch_prediction}, {31'd0, pred});
      check({tag, ".tgt"},  predicted_target,           tgt);
      tick("lookup");
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      exp_lookups = 32'd0;
      exp_mispred = 32'd0;
      idle();
      rst = 1'b0;

      // Outputs during reset
      #12;
      set_lookup(32'h40, 1'b1, 1'b0);
      #1;
      check("rst.hit",  {31'd0, btb_hit},           32'd0);
      check("rst.pred", {31'd0, branch_prediction}, 32'd0);
      check("rst.tgt",  predicted_target,           32'h44);
      check("rst.plk",  perf_lookups,               32'd0);
      check("rst.pmis", perf_mispredicts,           32'd0);
      idle();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Cold lookup misses
      do_lookup("cold", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44);

      // Allocate 0x40 -> 0x20 (counter weak taken)
      do_update(32'h40, 1'b1, 32'h20, 1'b0);
      do_lookup("alloc", 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20);

      // Two not-taken: counter 2 -> 0
      do_update(32'h40, 1'b0, 32'h0, 1'b0);
      do_update(32'h40, 1'b0, 32'h0, 1'b0);
      do_lookup("nt2", 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44);

      // Five taken saturate at 3, one not-taken leaves 2 (still taken)
      for (int i = 0; i < 5; i++) do_update(32'h40, 1'b1, 32'h20, 1'b0);
      do_lookup("sat", 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20);
      do_update(32'h40, 1'b0, 32'h0, 1'b0);
      do_lookup("sat_nt", 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20);

      // Same index, different tag: 0x140 replaces 0x40
      do_update(32'h140, 1'b1, 32'h300, 1'b0);
      do_lookup("alias_old", 32'h40,  1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
      do_lookup("alias_new", 32'h140, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300);

      // Not-taken miss must not allocate
      do_update(32'h240, 1'b0, 32'h900, 1'b0);
      do_lookup("nt_miss", 32'h240, 1'b1, 1'b0, 1'b0, 1'b0, 32'h244);

      // Lookup gated by lookup_valid / instruction type
      set_lookup(32'h140, 1'b0, 1'b0);
      #1;
      check("notype.hit", {31'd0, btb_hit}, 32'd0);
      tick("lookup");

      // Same-cycle lookup and first update of 0x80: lookup sees old contents
      set_lookup(32'h80, 1'b1, 1'b0);
      set_update(32'h80, 1'b1, 32'h500, 1'b0, 1'b0);
      #1;
      check("rbw.hit",  {31'd0, btb_hit},           32'd0);
      check("rbw.pred", {31'd0, branch_prediction}, 32'd0);
      check("rbw.tgt",  predicted_target,           32'h84);
      tick("lookup+update");
      do_lookup("rbw_next", 32'h80, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500);

      // Flush with a simultaneous allocate-capable update: flush wins
      check("preflush.plk", perf_lookups, exp_lookups);
      flush_table = 1'b1;
      set_update(32'h1C0, 1'b1, 32'h600, 1'b0, 1'b0);
      tick("flush");
      check("flush.plk",  perf_lookups,     exp_lookups);
      check("flush.pmis", perf_mispredicts, exp_mispred);
      do_lookup("flush_80",  32'h80,  1'b1, 1'b0, 1'b0, 1'b0, 32'h84);
      do_lookup("flush_140", 32'h140, 1'b1, 1'b0, 1'b0, 1'b0, 32'h144);
      do_lookup("flush_1c0", 32'h1C0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1C4);

      // Jump flag forces taken even with counter at 0
      do_update(32'hC0, 1'b1, 32'h1000, 1'b1);
      do_update(32'hC0, 1'b0, 32'h0, 1'b0);
      do_update(32'hC0, 1'b0, 32'h0, 1'b0);
      do_lookup("jal", 32'hC0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000);

      // Perf counters track stimulus
      check("perf.plk", perf_lookups, exp_lookups);
      set_update(32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
      tick("mispredict");
      check("perf.pmis", perf_mispredicts, exp_mispred);

      // Mispredict counter wraps
      @(negedge clk);
      force dut.perf_mispredicts_q = 32'hFFFF_FFFF;
      #1;
      release dut.perf_mispredicts_q;
      exp_mispred = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      check("wrap.pre", perf_mispredicts, exp_mispred);
      set_update(32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
      tick("mispredict");
      check("wrap.post", perf_mispredicts, 32'h0);

      // Asynchronous reset mid-run, with a lookup and an update in flight
      set_lookup(32'hC0, 1'b0, 1'b1);
      set_update(32'h100, 1'b1, 32'h700, 1'b0, 1'b0);
      #1;
      check("prerst.hit", {31'd0, btb_hit}, 32'd1);
      rst = 1'b0;
      #1;
      check("arst.hit",  {31'd0, btb_hit},           32'd0);
      check("arst.pred", {31'd0, branch_prediction}, 32'd0);
      check("arst.tgt",  predicted_target,           32'hC4);
      check("arst.plk",  perf_lookups,               32'd0);
      check("arst.pmis", perf_mispredicts,           32'd0);
      exp_lookups = 32'd0;
      exp_mispred = 32'd0;
      tick("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      do_lookup("post_c0",  32'hC0,  1'b0, 1'b1, 1'b0, 1'b0, 32'hC4);
      do_lookup("post_100", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
      check("post.plk", perf_lookups, exp_lookups);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, table depth, power of two, 4..1024.
REQ-002 SHALL have parameter CTR_BITS, default 2, saturating-counter width, 2..4.
REQ-003 SHALL have parameter TAG_BITS, default 8, stored PC tag width, 1..16.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port lookup_valid  input  1  ID stage holds a valid instruction.
REQ-007 SHALL have port pc_in  input  32  PC of the ID instruction.
REQ-008 SHALL have port pc_plus_4_in  input  32  fall-through PC.
REQ-009 SHALL have port is_branch  input  1  ID instruction is a conditional branch.
REQ-010 SHALL have port is_jump  input  1  ID instruction is JAL.
REQ-011 SHALL have port branch_prediction  output  1  predict taken.
REQ-012 SHALL have port predicted_target  output  32  predicted next PC.
REQ-013 SHALL have port btb_hit  output  1  valid entry with matching tag.
REQ-014 SHALL have port update_valid  input  1  EX/MEM resolved a branch or jump this cycle.
REQ-015 SHALL have port update_pc  input  32  PC of the resolved instruction.
REQ-016 SHALL have port update_taken  input  1  actual outcome.
REQ-017 SHALL have port update_target  input  32  actual target.
REQ-018 SHALL have port update_is_jump  input  1  resolved instruction is JAL.
REQ-019 SHALL have port update_mispredict  input  1  EX detected misprediction.
REQ-020 SHALL have port flush_table  input  1  invalidate all entries.
REQ-021 SHALL have port perf_lookups  output  32  predicted-instruction count.
REQ-022 SHALL have port perf_mispredicts  output  32  misprediction count.

Function
REQ-023 SHALL compute index = pc[IDX+1:2], IDX = log2(ENTRIES), and tag = pc[IDX+TAG_BITS+1:IDX+2], for both lookup and update PCs.
REQ-024 SHALL hold per entry: valid, tag, jump flag, 32-bit target, CTR_BITS counter.
REQ-025 SHALL make lookup combinational from pc_in; btb_hit = lookup_valid & (is_branch|is_jump) & valid & tag match.
REQ-026 SHALL assert branch_prediction = btb_hit & (entry jump flag | counter MSB).
REQ-027 SHALL drive predicted_target = entry target when branch_prediction, else pc_plus_4_in.
REQ-028 SHALL, on update_valid with hit at update index: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_BITS-1; write target and jump flag only when taken.
REQ-029 SHALL, on update_valid with miss and update_taken=1: allocate (overwrite) entry: valid=1, tag, target, jump flag, counter = 2^(CTR_BITS-1) (weak taken).
REQ-030 SHALL NOT allocate on a miss with update_taken=0.
REQ-031 SHALL give lookup and update in the same cycle to the same entry read-before-write: lookup sees pre-update contents.
REQ-032 SHALL clear all valid bits on flush_table in one cycle; flush with simultaneous update: flush wins, update discarded.
REQ-033 SHALL increment perf_lookups when lookup_valid & (is_branch|is_jump); perf_mispredicts when update_valid & update_mispredict; both wrap modulo 2^32; flush_table does not affect them.

Reset
REQ-034 SHALL on rst low immediately clear all valid bits, set all counters to 2^(CTR_BITS-1)-1 (weak not-taken), tags/targets/jump flags to 0, perf counters to 0.
REQ-035 SHALL, during reset, drive branch_prediction=0, btb_hit=0, predicted_target=pc_plus_4_in; reset mid-update discards the update.

Structure
REQ-036 SHALL place index/tag slicing constants, counter init values and entry field widths in shared package bp_pkg.
REQ-037 SHALL implement the saturating increment/decrement in one sub-module bp_sat_ctr (combinational, CTR_BITS parameter), instantiated once on the update path.

Verification
REQ-038 SHALL cover: after reset, lookup pc=0x40 is_branch=1 -> btb_hit=0, prediction=0, target=0x44.
REQ-039 SHALL cover: update pc=0x40 taken target=0x20, next cycle lookup 0x40 -> hit=1, prediction=1, target=0x20.
REQ-040 SHALL cover: two not-taken updates after REQ-039 -> counter 0, prediction=0; five taken updates -> counter saturates at 3, one not-taken -> still predicts taken.
REQ-041 SHALL cover: ENTRIES=64, update pc=0x40 then pc=0x140 (same index, different tag) taken -> lookup 0x40 misses, 0x140 hits.
REQ-042 SHALL cover: same-cycle lookup and first update of 0x80 -> prediction=0 that cycle, 1 next cycle; flush_table with update -> next lookup misses, perf counters unchanged.
REQ-043 SHALL cover: perf_mispredicts preloaded to 0xFFFFFFFF by forcing, one mispredict -> wraps to 0x00000000; rst low mid-run -> all outputs to reset values same cycle.
